// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clock_divider_pkg;

  localparam int unsigned DIV_WIDTH = 8;
  localparam int unsigned MIN_DIV   = 2;

  typedef logic [DIV_WIDTH-1:0] div_t;

  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    return (n < MIN_DIV) ? 32'(MIN_DIV) : n;
  endfunction

endpackage

// File: rtl/clock_divider_phase.sv
// Phase counter with registered clk_out and rise/fall strobe decode.
// Stopped state (ph held at 0) is entered at a wrap when i_run_en is low.
module clock_divider_phase
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_cur_div,
  input  logic [WIDTH-1:0] i_next_div,
  input  logic             i_run_en,
  output logic             o_boundary,
  output logic             o_clk_out,
  output logic             o_rise_strobe,
  output logic             o_fall_strobe
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_ph;
  logic [WIDTH-1:0] w_ph_d;
  logic             r_stopped;
  logic             w_stopped_d;
  logic             r_clk;
  logic             w_wrap;
  logic             w_active;

  assign w_wrap   = !r_stopped && (r_ph == i_cur_div - ONE);
  assign w_active = !r_stopped || i_run_en;

  always_comb begin
    w_ph_d      = r_ph + ONE;
    w_stopped_d = r_stopped;
    if (r_stopped) begin
      // The last stopped cycle doubles as phase 0 of the resumed period.
      w_ph_d      = i_run_en ? ONE : '0;
      w_stopped_d = !i_run_en;
    end else if (w_wrap) begin
      w_ph_d      = '0;
      w_stopped_d = !i_run_en;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ph      <= '0;
      r_stopped <= 1'b0;
      r_clk     <= 1'b0;
    end else begin
      r_ph      <= w_ph_d;
      r_stopped <= w_stopped_d;
      r_clk     <= !w_stopped_d && (w_ph_d >= i_next_div - (i_next_div >> 1));
    end
  end

  assign o_boundary    = w_wrap || (r_stopped && !i_run_en);
  assign o_clk_out     = r_clk;
  assign o_rise_strobe = w_active && (r_ph == i_cur_div - (i_cur_div >> 1) - ONE);
  assign o_fall_strobe = w_wrap;

endmodule

// File: rtl/clock_divider_prog.sv
// Programmable integer clock divider with glitch-free divisor update.
// Define CLOCK_DIVIDER_PROG_GATE_EN to add the clk_en period-boundary gate.
module clock_divider_prog
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
`ifdef CLOCK_DIVIDER_PROG_GATE_EN
  input  logic             clk_en,
`endif
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [WIDTH-1:0] div_bits,
  output logic             clk_out,
  output logic             rise_strobe,
  output logic             fall_strobe,
  output logic [WIDTH-1:0] cur_div,
  output logic             pending
);

  logic [WIDTH-1:0] r_cur_div;
  logic [WIDTH-1:0] w_cur_div_d;
  logic [WIDTH-1:0] r_pend_div;
  logic [WIDTH-1:0] w_pend_div_d;
  logic             r_pending;
  logic             w_pending_d;
  logic [WIDTH-1:0] w_clamped;
  logic             w_accept;
  logic             w_boundary;
  logic             w_run_en;

`ifdef CLOCK_DIVIDER_PROG_GATE_EN
  assign w_run_en = clk_en;
`else
  assign w_run_en = 1'b1;
`endif

  assign w_accept  = div_valid && !r_pending;
  assign w_clamped = WIDTH'(clamp_div(32'(div_bits)));

  always_comb begin
    w_cur_div_d  = r_cur_div;
    w_pend_div_d = r_pend_div;
    w_pending_d  = r_pending;
    if (w_boundary && r_pending) begin
      w_cur_div_d = r_pend_div;
      w_pending_d = 1'b0;
    end else if (w_accept && w_boundary) begin
      // Request lands exactly on the boundary: skip the pending slot.
      w_cur_div_d = w_clamped;
    end else if (w_accept) begin
      w_pend_div_d = w_clamped;
      w_pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cur_div  <= WIDTH'(DEFAULT_DIV);
      r_pend_div <= WIDTH'(DEFAULT_DIV);
      r_pending  <= 1'b0;
    end else begin
      r_cur_div  <= w_cur_div_d;
      r_pend_div <= w_pend_div_d;
      r_pending  <= w_pending_d;
    end
  end

  clock_divider_phase #(
    .WIDTH (WIDTH)
  ) u_phase (
    .clock         (clock),
    .reset         (reset),
    .i_cur_div     (r_cur_div),
    .i_next_div    (w_cur_div_d),
    .i_run_en      (w_run_en),
    .o_boundary    (w_boundary),
    .o_clk_out     (clk_out),
    .o_rise_strobe (rise_strobe),
    .o_fall_strobe (fall_strobe)
  );

  assign div_ready = !r_pending;
  assign cur_div   = r_cur_div;
  assign pending   = r_pending;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboarded bench for clock_divider_prog: the driver queues hand-computed
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_clock_divider_prog;
  import clock_divider_pkg::*;

  typedef struct packed {
    logic clk;
    logic rise;
    logic fall;
    logic rdy;
    logic pnd;
    div_t cur;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic div_valid = 1'b0;
  div_t div_bits = '0;
  logic clk_en = 1'b1;
  logic div_ready, clk_out, rise_strobe, fall_strobe, pending;
  div_t cur_div;

  obs_t exp_q[$];
  int   idx_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  always #5 clock = ~clock;

  clock_divider_prog #(
    .WIDTH       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef CLOCK_DIVIDER_PROG_GATE_EN
    .clk_en      (clk_en),
`endif
    .div_valid   (div_valid),
    .div_ready   (div_ready),
    .div_bits    (div_bits),
    .clk_out     (clk_out),
    .rise_strobe (rise_strobe),
    .fall_strobe (fall_strobe),
    .cur_div     (cur_div),
    .pending     (pending)
  );

  // Expected values describe the state seen during this cycle; the inputs
  // given are driven during the same cycle and take effect at its end.
  task automatic cyc(input logic rst, input logic v, input int b, input logic en,
                     input logic ck, input logic rs, input logic fs,
                     input logic rdy, input logic pnd, input int cd);
    obs_t e;
    @(posedge clock);
    #1;
    reset     = rst;
    div_valid = v;
    div_bits  = div_t'(b);
    clk_en    = en;
    e.clk = ck; e.rise = rs; e.fall = fs; e.rdy = rdy; e.pnd = pnd; e.cur = div_t'(cd);
    exp_q.push_back(e);
    idx_q.push_back(cyc_no);
    cyc_no++;
  endtask

  always @(negedge clock) begin
    obs_t e, a;
    int   k;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      k = idx_q.pop_front();
      a.clk = clk_out; a.rise = rise_strobe; a.fall = fall_strobe;
      a.rdy = div_ready; a.pnd = pending; a.cur = cur_div;
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_%0d: got clk=%b rise=%b fall=%b rdy=%b pnd=%b cur=%0d, want clk=%b rise=%b fall=%b rdy=%b pnd=%b cur=%0d",
                 k, a.clk, a.rise, a.fall, a.rdy, a.pnd, a.cur,
                 e.clk, e.rise, e.fall, e.rdy, e.pnd, e.cur);
      end
    end
  end

  initial begin
    @(posedge clock);
    // Reset state, then divide-by-2 free run.
    cyc(1, 0, 0, 1,  0, 1, 0, 1, 0, 2);
    for (int i = 1; i <= 8; i++) begin
      if (i % 2 == 1) cyc(0, 0, 0, 1,  0, 1, 0, 1, 0, 2);
      else            cyc(0, 0, 0, 1,  1, 0, 1, 1, 0, 2);
    end
    // Program N=5 at ph 0: pending until wrap, then low 3 / high 2.
    cyc(0, 1, 5, 1,  0, 1, 0, 1, 0, 2);
    cyc(0, 0, 0, 1,  1, 0, 1, 0, 1, 2);
    cyc(0, 0, 0, 1,  0, 0, 0, 1, 0, 5);
    cyc(0, 0, 0, 1,  0, 0, 0, 1, 0, 5);
    cyc(0, 0, 0, 1,  0, 1, 0, 1, 0, 5);
    cyc(0, 0, 0, 1,  1, 0, 0, 1, 0, 5);
    cyc(0, 0, 0, 1,  1, 0, 1, 1, 0, 5);
    // N=0 clamps to 2; a second request while pending is ignored.
    cyc(0, 1, 0, 1,  0, 0, 0, 1, 0, 5);
    cyc(0, 1, 7, 1,  0, 0, 0, 0, 1, 5);
    cyc(0, 0, 0, 1,  0, 1, 0, 0, 1, 5);
    cyc(0, 0, 0, 1,  1, 0, 0, 0, 1, 5);
    cyc(0, 0, 0, 1,  1, 0, 1, 0, 1, 5);
    // N=1 clamps to 2.
    cyc(0, 1, 1, 1,  0, 1, 0, 1, 0, 2);
    cyc(0, 0, 0, 1,  1, 0, 1, 0, 1, 2);
    cyc(0, 0, 0, 1,  0, 1, 0, 1, 0, 2);
    // N=4 offered on the wrap cycle: applied directly, pending stays low.
    cyc(0, 1, 4, 1,  1, 0, 1, 1, 0, 2);
    cyc(0, 0, 0, 1,  0, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 1,  0, 1, 0, 1, 0, 4);
    cyc(0, 0, 0, 1,  1, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 1,  1, 0, 1, 1, 0, 4);
    // Move to N=6, queue N=3, then reset at ph 2.
    cyc(0, 1, 6, 1,  0, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 1,  0, 1, 0, 0, 1, 4);
    cyc(0, 0, 0, 1,  1, 0, 0, 0, 1, 4);
    cyc(0, 0, 0, 1,  1, 0, 1, 0, 1, 4);
    cyc(0, 1, 3, 1,  0, 0, 0, 1, 0, 6);
    cyc(0, 1, 9, 1,  0, 0, 0, 0, 1, 6);
    cyc(1, 0, 0, 1,  0, 1, 0, 0, 1, 6);
    cyc(0, 0, 0, 1,  0, 1, 0, 1, 0, 2);
    cyc(0, 0, 0, 1,  1, 0, 1, 1, 0, 2);
    cyc(0, 0, 0, 1,  0, 1, 0, 1, 0, 2);
`ifdef CLOCK_DIVIDER_PROG_GATE_EN
    // N=4, drop clk_en at ph 1: period completes, then hold low; resume.
    cyc(0, 1, 4, 1,  1, 0, 1, 1, 0, 2);
    cyc(0, 0, 0, 1,  0, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 0,  0, 1, 0, 1, 0, 4);
    cyc(0, 0, 0, 0,  1, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 0,  1, 0, 1, 1, 0, 4);
    cyc(0, 0, 0, 0,  0, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 0,  0, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 1,  0, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 1,  0, 1, 0, 1, 0, 4);
    cyc(0, 0, 0, 1,  1, 0, 0, 1, 0, 4);
    cyc(0, 0, 0, 1,  1, 0, 1, 1, 0, 4);
    cyc(0, 0, 0, 1,  0, 0, 0, 1, 0, 4);
`endif
    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
